booth_mul_seq: RTL and testbench



---
 rtl/booth_mul_pkg.sv | 42 ++++
 rtl/booth_mul_seq_pp_gen.sv | 28 ++
 rtl/booth_mul_seq.sv | 158 +++++++++++++++
 tb/tb_booth_mul_seq.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier:
// controller states, digit-select encodings and the digit-count function.
package booth_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4
    } digit_sel_e;

    // Number of radix-4 digits needed to cover a width-bit operand in either mode.
    function automatic int calc_ndig(input int width);
        return (width + 2) / 2;
    endfunction

    // bits = {b[2j+1], b[2j], b[2j-1]}; digit = -2*b[2j+1] + b[2j] + b[2j-1]
    function automatic digit_sel_e booth_decode(input logic [2:0] bits);
        digit_sel_e sel;
        sel = ZERO;
        case (bits)
            3'b000:  sel = ZERO;
            3'b001:  sel = P1;
            3'b010:  sel = P1;
            3'b011:  sel = P2;
            3'b100:  sel = M2;
            3'b101:  sel = M1;
            3'b110:  sel = M1;
            3'b111:  sel = ZERO;
            default: sel = ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_mul_seq_pp_gen.sv
// One Booth partial-product generator: three multiplier bits select
// 0, +/-a_ext or +/-2*a_ext, all within WIDTH+2 bits.
module booth_pp_gen
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = 11
) (
    input  logic [2:0]       bits_i,
    input  logic [WIDTH+1:0] a_ext_i,
    output logic [WIDTH+1:0] pp_o
);

    digit_sel_e sel;

    assign sel = booth_decode(bits_i);

    always_comb begin
        pp_o = '0;
        case (sel)
            P1:      pp_o = a_ext_i;
            P2:      pp_o = a_ext_i << 1;
            M1:      pp_o = -a_ext_i;
            M2:      pp_o = -(a_ext_i << 1);
            default: pp_o = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier retiring DPC digits per clock behind a
// valid/ready handshake. Define BOOTH_MUL_EARLY_TERM_EN to stop once the remaining digits are all zero.
module booth_mul_seq
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int DPC   = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic [3:0]           cycles
);

    localparam int NDIG = calc_ndig(WIDTH);
    localparam int AW   = WIDTH + 2;
    localparam int ACCW = 2 * WIDTH + 2;
    localparam int BW   = 2 * NDIG;
    localparam int KW   = $clog2(NDIG + DPC + 1);
    localparam logic [KW-1:0] K_STEP = KW'(DPC);
    localparam logic [KW-1:0] K_LAST = KW'(NDIG);

    state_e               state_q, state_d;
    logic [AW-1:0]        a_ext_q, a_ext_d;
    logic [BW:0]          b_pad_q, b_pad_d;
    logic [ACCW-1:0]      acc_q, acc_d;
    logic [KW-1:0]        k_q, k_d;
    logic [3:0]           run_cnt_q, run_cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [3:0]           cycles_q, cycles_d;

    logic                 a_sx;
    logic                 b_sx;
    logic [KW-1:0]        k_next;
    logic [ACCW-1:0]      pp_sum;
    logic                 stop_early;

    logic [KW-1:0]        dig_idx  [DPC];
    logic [2:0]           dig_bits [DPC];
    logic [AW-1:0]        pp       [DPC];
    logic [ACCW-1:0]      pp_sh    [DPC];

    assign a_sx   = is_signed & a[WIDTH-1];
    assign b_sx   = is_signed & b[WIDTH-1];
    assign k_next = k_q + K_STEP;

    // b_pad_q holds b_ext with a zero appended below bit 0, so digit j reads bits [2j+2:2j].
    for (genvar gi = 0; gi < DPC; gi++) begin : g_digit
        assign dig_idx[gi]  = k_q + KW'(gi);
        assign dig_bits[gi] = (dig_idx[gi] < K_LAST) ? 3'(b_pad_q >> {dig_idx[gi], 1'b0}) : 3'b000;

        booth_pp_gen #(
            .WIDTH (WIDTH)
        ) u_pp_gen (
            .bits_i  (dig_bits[gi]),
            .a_ext_i (a_ext_q),
            .pp_o    (pp[gi])
        );

        assign pp_sh[gi] = {{(ACCW-AW){pp[gi][AW-1]}}, pp[gi]} << {dig_idx[gi], 1'b0};
    end

    always_comb begin
        pp_sum = '0;
        for (int i = 0; i < DPC; i++) begin
            pp_sum = pp_sum + pp_sh[i];
        end
    end

`ifdef BOOTH_MUL_EARLY_TERM_EN
    // Remaining digits are all zero exactly when b_ext[2k-1 and up] is a run of one value.
    logic signed [BW:0] b_rest;
    assign b_rest     = $signed(b_pad_q) >>> {k_q, 1'b0};
    assign stop_early = (b_rest == '0) || (b_rest == '1);
`else
    assign stop_early = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        a_ext_d   = a_ext_q;
        b_pad_d   = b_pad_q;
        acc_d     = acc_q;
        k_d       = k_q;
        run_cnt_d = run_cnt_q;
        p_d       = p_q;
        cycles_d  = cycles_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_ext_d   = {{2{a_sx}}, a};
                    b_pad_d   = {{(BW-WIDTH){b_sx}}, b, 1'b0};
                    acc_d     = '0;
                    k_d       = '0;
                    run_cnt_d = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (stop_early) begin
                    p_d      = acc_q[2*WIDTH-1:0];
                    cycles_d = run_cnt_q;
                    state_d  = DONE;
                end else begin
                    acc_d     = acc_q + pp_sum;
                    k_d       = k_next;
                    run_cnt_d = run_cnt_q + 4'd1;
                    if (k_next >= K_LAST) begin
                        p_d      = acc_d[2*WIDTH-1:0];
                        cycles_d = run_cnt_q + 4'd1;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            a_ext_q   <= '0;
            b_pad_q   <= '0;
            acc_q     <= '0;
            k_q       <= '0;
            run_cnt_q <= '0;
            p_q       <= '0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            a_ext_q   <= a_ext_d;
            b_pad_q   <= b_pad_d;
            acc_q     <= acc_d;
            k_q       <= k_d;
            run_cnt_q <= run_cnt_d;
            p_q       <= p_d;
            cycles_q  <= cycles_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign p         = p_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq: a DPC=1 and a DPC=3 instance driven in lockstep,
// table vectors, handshake/reset corner sequences and scoreboarded random pairs.
module tb_booth_mul_seq;

    localparam int W    = 11;
    localparam int NDIG = 6;

    logic           clock = 1'b0;
    logic           reset;
    logic           in_valid;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           is_signed;
    logic           out_ready;

    logic           in_ready, out_valid;
    logic [2*W-1:0] p;
    logic [3:0]     cycles;
    logic           in_ready3, out_valid3;
    logic [2*W-1:0] p3;
    logic [3:0]     cycles3;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           s;
        logic [2*W-1:0] p;
    } vec_t;

    typedef struct {
        logic [2*W-1:0] p;
        logic [3:0]     c;
        int             lat;
        int             t;
    } exp_t;

    exp_t sb1[$];
    exp_t sb3[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_cnt  = 0;
    logic ov1_prev = 1'b0;
    logic ov3_prev = 1'b0;

    always #5 clock = ~clock;

    booth_mul_seq #(.WIDTH(W), .DPC(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .cycles    (cycles)
    );

    booth_mul_seq #(.WIDTH(W), .DPC(3)) dut3 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready3),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .p         (p3),
        .cycles    (cycles3)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    function automatic void timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=no handshake required=handshake within 50 clocks", name);
    endfunction

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        longint xa, ya;
        xa = s ? longint'($signed(x)) : longint'(x);
        ya = s ? longint'($signed(y)) : longint'(y);
        return (2*W)'(xa * ya);
    endfunction

    function automatic int exp_cycles(input logic [W-1:0] bv, input logic s, input int dpc);
        int n;
`ifdef BOOTH_MUL_EARLY_TERM_EN
        logic [2*NDIG:0] bp;
        logic            uni;
        bp = {s & bv[W-1], bv, 1'b0};
        n  = 0;
        for (int k = 0; k < NDIG; k += dpc) begin
            uni = 1'b1;
            for (int i = 2*k; i <= 2*NDIG; i++) begin
                if (bp[i] != bp[2*NDIG]) uni = 1'b0;
            end
            if (uni) return n;
            n++;
        end
`else
        n = (NDIG + dpc - 1) / dpc;
`endif
        return n;
    endfunction

    function automatic int exp_lat(input logic [W-1:0] bv, input logic s, input int dpc);
        int c, full;
        c    = exp_cycles(bv, s, dpc);
        full = (NDIG + dpc - 1) / dpc;
        return (c == full) ? full : c + 1;
    endfunction

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clock) begin
        if (reset) begin
            sb1.delete();
            ov1_prev <= 1'b0;
        end else begin
            if (out_valid && !ov1_prev) begin
                if (sb1.size() == 0) timeout("orphan_valid1");
                else check("latency1", 64'(cyc_cnt - sb1[0].t), 64'(sb1[0].lat));
            end
            if (out_valid && out_ready) begin
                if (sb1.size() == 0) timeout("orphan_out1");
                else begin
                    check("p1", 64'(p), 64'(sb1[0].p));
                    check("cycles1", 64'(cycles), 64'(sb1[0].c));
                    $display("txn dut1 p=0x%06h cycles=%0d", p, cycles);
                    void'(sb1.pop_front());
                end
            end
            if (in_valid && in_ready)
                sb1.push_back('{ref_mul(a, b, is_signed), 4'(exp_cycles(b, is_signed, 1)),
                                exp_lat(b, is_signed, 1), cyc_cnt + 1});
            ov1_prev <= out_valid;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            sb3.delete();
            ov3_prev <= 1'b0;
        end else begin
            if (out_valid3 && !ov3_prev) begin
                if (sb3.size() == 0) timeout("orphan_valid3");
                else check("latency3", 64'(cyc_cnt - sb3[0].t), 64'(sb3[0].lat));
            end
            if (out_valid3 && out_ready) begin
                if (sb3.size() == 0) timeout("orphan_out3");
                else begin
                    check("p3", 64'(p3), 64'(sb3[0].p));
                    check("cycles3", 64'(cycles3), 64'(sb3[0].c));
                    $display("txn dut3 p=0x%06h cycles=%0d", p3, cycles3);
                    void'(sb3.pop_front());
                end
            end
            if (in_valid && in_ready3)
                sb3.push_back('{ref_mul(a, b, is_signed), 4'(exp_cycles(b, is_signed, 3)),
                                exp_lat(b, is_signed, 3), cyc_cnt + 1});
            ov3_prev <= out_valid3;
        end
    end

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(out_valid && out_valid3) && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 50) timeout(name);
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                          output logic [2*W-1:0] r1, output logic [2*W-1:0] r3);
        int n;
        a         = av;
        b         = bv;
        is_signed = sv;
        in_valid  = 1'b1;
        n = 0;
        while (!(in_ready && in_ready3) && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 50) timeout("accept_wait");
        @(posedge clock); #1;
        in_valid = 1'b0;
        wait_done("result_wait");
        r1 = p;
        r3 = p3;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=time limit reached required=$finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t           vecs[12];
        logic [2*W-1:0] r1, r3;
        logic [W-1:0]   rb;

        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready",   64'(in_ready),   64'(1));
        check("rst_out_valid",  64'(out_valid),  64'(0));
        check("rst_p",          64'(p),          64'(0));
        check("rst_cycles",     64'(cycles),     64'(0));
        check("rst_in_ready3",  64'(in_ready3),  64'(1));
        check("rst_out_valid3", 64'(out_valid3), 64'(0));
        reset = 1'b0;

        vecs[0]  = '{11'd2047, 11'd2047, 1'b0, 22'h3FF001};
        vecs[1]  = '{11'h400,  11'h400,  1'b1, 22'h100000};
        vecs[2]  = '{11'h7FF,  11'h001,  1'b1, 22'h3FFFFF};
        vecs[3]  = '{11'd100,  11'd1,    1'b0, 22'h000064};
        vecs[4]  = '{11'd5,    11'h7F9,  1'b1, 22'h3FFFDD};
        vecs[5]  = '{11'd0,    11'h7FF,  1'b1, 22'h000000};
        vecs[6]  = '{11'h7FF,  11'h7FF,  1'b1, 22'h000001};
        vecs[7]  = '{11'h400,  11'h3FF,  1'b1, 22'h300400};
        vecs[8]  = '{11'h400,  11'h400,  1'b0, 22'h100000};
        vecs[9]  = '{11'h7FF,  11'h001,  1'b0, 22'h0007FF};
        vecs[10] = '{11'd3,    11'd4,    1'b0, 22'h00000C};
        vecs[11] = '{11'h3FF,  11'h3FF,  1'b1, 22'h0FF801};

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, r1, r3);
            check($sformatf("vec%0d_p1", i), 64'(r1), 64'(vecs[i].p));
            check($sformatf("vec%0d_p3", i), 64'(r3), 64'(vecs[i].p));
        end

        // Backpressure: result held while out_ready is low; a waiting request enters only from IDLE.
        a         = 11'd21;
        b         = 11'd2;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        @(posedge clock); #1;
        a = 11'd7;
        b = 11'd9;
        wait_done("bp_wait");
        for (int i = 0; i < 5; i++) begin
            check("bp_p",         64'(p),         64'(42));
            check("bp_p3",        64'(p3),        64'(42));
            check("bp_in_ready",  64'(in_ready),  64'(0));
            check("bp_out_valid", 64'(out_valid), 64'(1));
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check("bp_idle_in_ready",  64'(in_ready),  64'(1));
        check("bp_idle_out_valid", 64'(out_valid), 64'(0));
        @(posedge clock); #1;
        in_valid = 1'b0;
        check("bp_taken_in_ready", 64'(in_ready), 64'(0));
        wait_done("bp_second_wait");
        check("bp_second_p", 64'(p), 64'(63));
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;

        // Reset sampled on the third RUN clock aborts the multiply.
        a         = 11'd100;
        b         = 11'd37;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("rr_in_ready",   64'(in_ready),   64'(1));
        check("rr_out_valid",  64'(out_valid),  64'(0));
        check("rr_p",          64'(p),          64'(0));
        check("rr_cycles",     64'(cycles),     64'(0));
        check("rr_out_valid3", 64'(out_valid3), 64'(0));
        check("rr_p3",         64'(p3),         64'(0));
        run_op(11'd3, 11'd4, 1'b0, r1, r3);
        check("rr_fresh_p1", 64'(r1), 64'(12));
        check("rr_fresh_p3", 64'(r3), 64'(12));

        // Random pairs; every fourth uses a short multiplier to exercise early digits of zero.
        for (int i = 0; i < 300; i++) begin
            rb = (i % 4 == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
            run_op(W'($urandom), rb, 1'($urandom), r1, r3);
        end

        check("sb1_drained", 64'(sb1.size()), 64'(0));
        check("sb3_drained", 64'(sb3.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
